// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Optional same-cycle write bypass is enabled with REGFILE_BYPASS_EN.
package regfile_sb_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_REG_BITS = 4;
  localparam int DEPTH        = 1 << DEF_REG_BITS;
  localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on an accepted claim, cleared on writeback.
// Register 0 is never marked busy.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                claim,
  input  logic [REG_BITS-1:0] c_index,
  input  logic                rel,
  input  logic [REG_BITS-1:0] r_index,
  input  logic [REG_BITS-1:0] a_index,
  input  logic [REG_BITS-1:0] b_index,
  output logic                a_busy,
  output logic                b_busy,
  output logic                claim_ack
);

  localparam int NREGS = 1 << REG_BITS;

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic             ack_s;

  // Claim acceptance and next busy vector; a same-index claim beats the release
  always_comb begin
    ack_s      = en & claim & ~busy_r[c_index];
    set_mask_s = '0;
    clr_mask_s = '0;
    if (ack_s && (c_index != REG_BITS'(ZERO_REG))) begin
      set_mask_s[c_index] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (en && rel && (r_index != REG_BITS'(ZERO_REG))) begin
      clr_mask_s[r_index] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read-side busy lookup
  always_comb begin
    a_busy    = en & busy_r[a_index] & (a_index != REG_BITS'(ZERO_REG));
    b_busy    = en & busy_r[b_index] & (b_index != REG_BITS'(ZERO_REG));
    claim_ack = ack_s;
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with sequential hardware clear and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [REG_BITS-1:0] a_index,
  input  logic [REG_BITS-1:0] b_index,
  output logic [WIDTH-1:0]    a_data,
  output logic [WIDTH-1:0]    b_data,
  output logic                a_busy,
  output logic                b_busy,
  input  logic                reg_write,
  input  logic [REG_BITS-1:0] w_index,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                claim,
  input  logic [REG_BITS-1:0] c_index,
  output logic                claim_ack
);

  localparam int NREGS = 1 << REG_BITS;
  localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(NREGS - 1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [REG_BITS-1:0] clr_idx_r;
  logic [REG_BITS-1:0] clr_idx_nxt_s;
  logic [WIDTH-1:0]    mem_r [NREGS];
  logic                run_s;
  logic                wr_en_s;
  logic                a_hit_s;
  logic                b_hit_s;
  logic                sb_a_busy_s;
  logic                sb_b_busy_s;

  assign run_s   = (state_r == RUN);
  assign wr_en_s = run_s & reg_write & (w_index != REG_BITS'(ZERO_REG));
  assign ready   = run_s;

  // Clear sweep: visit indices 1..NREGS-1 once, then enter RUN
  always_comb begin
    state_nxt_s   = state_r;
    clr_idx_nxt_s = clr_idx_r;
    case (state_r)
      CLEAR: begin
        clr_idx_nxt_s = clr_idx_r + REG_BITS'(1);
        if (clr_idx_r == LAST_IDX) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN: begin
        state_nxt_s   = RUN;
        clr_idx_nxt_s = clr_idx_r;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_idx_nxt_s = REG_BITS'(1);
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR;
      clr_idx_r <= REG_BITS'(1);
    end else begin
      state_r   <= state_nxt_s;
      clr_idx_r <= clr_idx_nxt_s;
    end
  end

  // Storage: the clear sweep owns the write port until RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[clr_idx_r] <= mem_r[clr_idx_r];
    end else if (state_r == CLEAR) begin
      mem_r[clr_idx_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[w_index] <= write_data;
    end
  end

  regfile_scoreboard #(
    .REG_BITS (REG_BITS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .en        (run_s),
    .claim     (claim),
    .c_index   (c_index),
    .rel       (reg_write),
    .r_index   (w_index),
    .a_index   (a_index),
    .b_index   (b_index),
    .a_busy    (sb_a_busy_s),
    .b_busy    (sb_b_busy_s),
    .claim_ack (claim_ack)
  );

  // Same-cycle forwarding hits
  always_comb begin
    a_hit_s = 1'b0;
    b_hit_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_s && (a_index == w_index)) begin
      a_hit_s = 1'b1;
    end else begin
      a_hit_s = 1'b0;
    end
    if (wr_en_s && (b_index == w_index)) begin
      b_hit_s = 1'b1;
    end else begin
      b_hit_s = 1'b0;
    end
`endif
  end

  // Read ports; register 0 and the CLEAR phase read as zero
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (!run_s || (a_index == REG_BITS'(ZERO_REG))) begin
      a_data = '0;
    end else if (a_hit_s) begin
      a_data = write_data;
    end else begin
      a_data = mem_r[a_index];
    end
    if (!run_s || (b_index == REG_BITS'(ZERO_REG))) begin
      b_data = '0;
    end else if (b_hit_s) begin
      b_data = write_data;
    end else begin
      b_data = mem_r[b_index];
    end
    a_busy = sb_a_busy_s & ~a_hit_s;
    b_busy = sb_b_busy_s & ~b_hit_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default WIDTH=16, REG_BITS=4).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [3:0]  a_index, b_index, w_index, c_index;
  logic [15:0] a_data, b_data, write_data;
  logic        a_busy, b_busy, reg_write, claim, claim_ack;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_sb dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .a_index    (a_index),
    .b_index    (b_index),
    .a_data     (a_data),
    .b_data     (b_data),
    .a_busy     (a_busy),
    .b_busy     (b_busy),
    .reg_write  (reg_write),
    .w_index    (w_index),
    .write_data (write_data),
    .claim      (claim),
    .c_index    (c_index),
    .claim_ack  (claim_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [15:0] d);
    reg_write = 1'b1; w_index = idx; write_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  // Reset for n cycles, then release; leaves the bench right after the last reset edge
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    claim = 1'b1; c_index = 4'd3;
    reg_write = 1'b1; w_index = 4'd6; write_data = 16'h1111;
    a_index = 4'd6; b_index = 4'd3;
    #1;
    total_cnt++;
    if (claim_ack !== 1'b0 || a_data !== 16'h0 || a_busy !== 1'b0)
      $display("FAIL clear_outputs ack=%b a_data=%h a_busy=%b required 0/0000/0", claim_ack, a_data, a_busy);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) begin
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL ready_low cycle %0d ready=%b required 0", i, ready);
      else pass_cnt++;
      tick();
      claim = 1'b0; reg_write = 1'b0;
    end
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL ready_high ready=%b required 1", ready);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (a_data !== 16'h0 || b_busy !== 1'b0)
      $display("FAIL clear_ignored r6=%h busy3=%b required 0000/0", a_data, b_busy);
    else pass_cnt++;
  endtask

  task automatic test_preload_clear();
    for (int i = 1; i < 16; i++) do_write(4'(i), 16'hFFFF);
    claim = 1'b1; c_index = 4'd9; tick(); claim = 1'b0;
    do_reset(3);
    for (int i = 0; i < 15; i++) tick();
    for (int i = 0; i < 16; i++) begin
      a_index = 4'(i); b_index = 4'(15 - i);
      #1;
      total_cnt++;
      if (a_data !== 16'h0 || b_data !== 16'h0 || a_busy !== 1'b0 || b_busy !== 1'b0)
        $display("FAIL preload_clear idx=%0d a=%h b=%h busy=%b%b required 0000/0000/00", i, a_data, b_data, a_busy, b_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    do_write(4'd5, 16'h1234);
    a_index = 4'd5; b_index = 4'd0; #1;
    total_cnt++;
    if (a_data !== 16'h1234 || b_data !== 16'h0)
      $display("FAIL write_read a=%h b=%h required 1234/0000", a_data, b_data);
    else pass_cnt++;
    do_write(4'd0, 16'hBEEF);
    a_index = 4'd0; b_index = 4'd5; #1;
    total_cnt++;
    if (a_data !== 16'h0 || b_data !== 16'h1234)
      $display("FAIL write_r0 a=%h b=%h required 0000/1234", a_data, b_data);
    else pass_cnt++;
  endtask

  task automatic test_claim();
    claim = 1'b1; c_index = 4'd3; #1;
    total_cnt++;
    if (claim_ack !== 1'b1) $display("FAIL claim_first ack=%b required 1", claim_ack);
    else pass_cnt++;
    tick(); claim = 1'b0; a_index = 4'd3; #1;
    total_cnt++;
    if (a_busy !== 1'b1) $display("FAIL claim_busy a_busy=%b required 1", a_busy);
    else pass_cnt++;
    claim = 1'b1; #1;
    total_cnt++;
    if (claim_ack !== 1'b0) $display("FAIL claim_again ack=%b required 0", claim_ack);
    else pass_cnt++;
    tick(); claim = 1'b0;
    do_write(4'd3, 16'h00AA);
    #1;
    total_cnt++;
    if (a_busy !== 1'b0 || a_data !== 16'h00AA)
      $display("FAIL release busy=%b data=%h required 0/00aa", a_busy, a_data);
    else pass_cnt++;
    claim = 1'b1; c_index = 4'd0; #1;
    total_cnt++;
    if (claim_ack !== 1'b1) $display("FAIL claim_r0 ack=%b required 1", claim_ack);
    else pass_cnt++;
    tick(); claim = 1'b0; a_index = 4'd0; #1;
    total_cnt++;
    if (a_busy !== 1'b0) $display("FAIL claim_r0_busy busy=%b required 0", a_busy);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [15:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 16'h0042;
`else
    exp_same = 16'h0000;
`endif
    a_index = 4'd7;
    reg_write = 1'b1; w_index = 4'd7; write_data = 16'h0042; #1;
    total_cnt++;
    if (a_data !== exp_same) $display("FAIL collision_same a=%h required %h", a_data, exp_same);
    else pass_cnt++;
    tick(); reg_write = 1'b0; #1;
    total_cnt++;
    if (a_data !== 16'h0042) $display("FAIL collision_next a=%h required 0042", a_data);
    else pass_cnt++;
  endtask

  task automatic test_same_index();
    claim = 1'b1; c_index = 4'd4; tick();
    reg_write = 1'b1; w_index = 4'd4; write_data = 16'h0404; #1;
    total_cnt++;
    if (claim_ack !== 1'b0) $display("FAIL same_busy_ack ack=%b required 0", claim_ack);
    else pass_cnt++;
    tick(); reg_write = 1'b0; claim = 1'b0; a_index = 4'd4; #1;
    total_cnt++;
    if (a_busy !== 1'b0 || a_data !== 16'h0404)
      $display("FAIL same_busy_after busy=%b data=%h required 0/0404", a_busy, a_data);
    else pass_cnt++;
    claim = 1'b1; reg_write = 1'b1; write_data = 16'h0444; #1;
    total_cnt++;
    if (claim_ack !== 1'b1) $display("FAIL same_free_ack ack=%b required 1", claim_ack);
    else pass_cnt++;
    tick(); reg_write = 1'b0; claim = 1'b0; #1;
    total_cnt++;
    if (a_busy !== 1'b1 || a_data !== 16'h0444)
      $display("FAIL same_free_after busy=%b data=%h required 1/0444", a_busy, a_data);
    else pass_cnt++;
    reg_write = 1'b1; w_index = 4'd9; write_data = 16'h9999;
    claim = 1'b1; c_index = 4'd10; #1;
    total_cnt++;
    if (claim_ack !== 1'b1) $display("FAIL diff_ack ack=%b required 1", claim_ack);
    else pass_cnt++;
    tick(); reg_write = 1'b0; claim = 1'b0; a_index = 4'd9; b_index = 4'd10; #1;
    total_cnt++;
    if (a_data !== 16'h9999 || a_busy !== 1'b0 || b_busy !== 1'b1)
      $display("FAIL diff_after a=%h abusy=%b bbusy=%b required 9999/0/1", a_data, a_busy, b_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_restart();
    do_write(4'd2, 16'h5555);
    do_reset(1);
    for (int i = 0; i < 7; i++) tick();
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL mid_clear_ready ready=%b required 0", ready);
    else pass_cnt++;
    do_reset(1);
    for (int i = 0; i < 15; i++) begin
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL restart_ready_low cycle %0d ready=%b required 0", i, ready);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL restart_ready_high ready=%b required 1", ready);
    else pass_cnt++;
    a_index = 4'd2; #1;
    total_cnt++;
    if (a_data !== 16'h0) $display("FAIL restart_r2 a=%h required 0000", a_data);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_index = 4'(i); #1;
      total_cnt++;
      if (a_busy !== 1'b0) $display("FAIL restart_busy idx=%0d busy=%b required 0", i, a_busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; a_index = '0; b_index = '0; w_index = '0; c_index = '0;
    write_data = '0; reg_write = 1'b0; claim = 1'b0;
    test_reset();
    test_preload_clear();
    test_write_read();
    test_claim();
    test_collision();
    test_same_index();
    test_reset_restart();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 2-read/1-write register file, used by the datapath for operand fetch and writeback.
- Adds a synchronous reset, a sequential hardware clear of all registers, and a separate write index.
- Adds a per-register busy scoreboard (claim on issue, release on writeback) so the controller can detect load-use hazards.
- Register 0 stays hardwired to zero.

Parameters:
- WIDTH, 16, data width of each register.
- REG_BITS, 4, index width; depth is 2**REG_BITS registers.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the hardware clear is done; reads and writes are valid only when high.
- a_index  in  REG_BITS  read port A index.
- b_index  in  REG_BITS  read port B index.
- a_data  out  WIDTH  read port A data, combinational.
- b_data  out  WIDTH  read port B data, combinational.
- a_busy  out  1  scoreboard bit for a_index, combinational.
- b_busy  out  1  scoreboard bit for b_index, combinational.
- reg_write  in  1  write enable.
- w_index  in  REG_BITS  write index.
- write_data  in  WIDTH  write data.
- claim  in  1  request to mark c_index busy (an instruction issued with this destination).
- c_index  in  REG_BITS  claim index.
- claim_ack  out  1  combinational; high when a claim is accepted this cycle.

Behaviour:
- Clock and reset are fixed: single clock clk; reset is synchronous and active-high.
- FSM has two states, CLEAR and RUN.
  - Edge with reset=1: state goes to CLEAR, clr_idx=1, all busy bits=0, ready=0.
  - In CLEAR, each edge writes 0 to RAM[clr_idx] and increments clr_idx.
  - After clearing index 2**REG_BITS-1, state goes to RUN.
  - ready rises exactly 2**REG_BITS-1 cycles after the first edge with reset low (15 cycles for the defaults).
  - ready = (state==RUN).
- While in CLEAR:
  - a_data, b_data, a_busy, b_busy and claim_ack are all 0.
  - reg_write and claim are ignored.
- Reset asserted mid-CLEAR or mid-RUN restarts the clear from clr_idx=1. Contents written before the reset are lost.
- Reads (RUN): x_data = RAM[x_index], forced to 0 when x_index==0. x_busy = busy[x_index], forced to 0 when x_index==0.
- Write (RUN): on an edge with reg_write=1 and w_index!=0, RAM[w_index] takes write_data and busy[w_index] clears. A write to index 0 is a no-op.
- Claim (RUN):
  - claim_ack = claim & ~busy[c_index].
  - For c_index==0: ack is 1 and busy stays 0.
  - On an edge with claim_ack=1, busy[c_index] is set.
  - A claim on a busy register gets ack=0 and changes no state; the requester retries.
- Write and claim to the same index (non-zero, currently busy) in one cycle:
  - The write lands and busy clears this edge.
  - claim_ack is 0 because it is evaluated against the pre-edge busy state.
- Write and claim to the same index when it is not busy: ack=1, the write lands, busy ends at 1 (claim wins).
- Write and claim to different indices: both take effect independently.
- Write-read collision with no bypass: a read in the same cycle returns the old value; the new value is visible from the next cycle.
- No arithmetic; all indices are unsigned, with no wrap beyond the depth.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In RUN, if reg_write=1, w_index!=0 and x_index==w_index, x_data = write_data in the same cycle.
  - x_busy reads as 0 in that case.
- Undefined:
  - Old value and old busy bit until the edge, as described above.
  - A read of the written register returns the new value from the next cycle.
- The clear behaviour is identical either way.

Decomposition:
- Shared package holds:
  - state enum {CLEAR, RUN};
  - localparam DEPTH = 1<<REG_BITS;
  - ZERO_REG = 0.
- One sub-module is natural: regfile_scoreboard, containing the busy-bit vector, claim/release logic and claim_ack.
- Storage, the clear FSM and bypass stay in the top.

Test Plan:
- Reset held 3 cycles, then released -> ready=0 for 15 cycles, then 1; every index reads 0 and busy=0, even after RAM was preloaded with 16'hFFFF.
- RUN: write 16'h1234 to r5, then set a_index=5 and b_index=0 the next cycle -> a_data=16'h1234, b_data=0. Write 16'hBEEF to r0 -> r0 still reads 0.
- Claim r3 -> claim_ack=1, and a_busy=1 next cycle. Claim r3 again -> ack=0. Write 16'h00AA to r3 -> busy=0 next cycle and data=16'h00AA.
- Same-cycle write of 16'h0042 to r7 with a_index=7:
  - with REGFILE_BYPASS_EN: a_data=16'h0042 in that cycle;
  - without: old value in that cycle, 16'h0042 the next.
- Same-edge write to r4 (busy) plus claim of r4 -> ack=0 and busy=0 after the edge. Repeat with r4 not busy -> ack=1, write lands, busy=1.
- Reset asserted at clr_idx=8 and again mid-RUN after writing r2=16'h5555 -> clear restarts, ready low 15 cycles, r2 reads 0 and all busy bits are 0.
